systolic_ctrl: RTL
==================

# systolic_ctrl

Sequencer for the weight-stationary PE chain. On each Start it optionally loads one weight per row from the weight buffer (broadcast with row ID and enable), waits for the weights to settle, then streams Num_Vec input vectors from the input buffer with psum address/valid tags. It drains the pipeline and pulses Done. It sits between the buffer SRAMs and the head PE (Row_ID 0) of the array.

## Interface
- NUM_ROW, 8, number of PE rows in the chain (≥2)
- BIT_ROW_ID, 3, row ID width (≥ clog2(NUM_ROW))
- BIT_DATA, 8, input/weight data width
- BIT_ADDR, 8, buffer and psum address width
- CLK  in  1  clock; all state changes on rising edge
- RSTN  in  1  reset, asynchronous, active-low
- Start  in  1  launch request, sampled only in IDLE
- Skip_W  in  1  reuse resident weights (skip weight load), sampled with Start
- Num_Vec  in  BIT_ADDR  vectors to stream, sampled with Start
- W_Base, I_Base, O_Base  in  BIT_ADDR each  weight/input/psum base addresses, sampled with Start
- Busy  out  1  high in every non-IDLE state
- Done  out  1  one-cycle pulse in DONE
- W_Rd_En, W_Rd_Addr  out  1, BIT_ADDR  weight buffer read; data returns next cycle
- W_Rd_Data  in  BIT_DATA  weight buffer read data
- I_Rd_En, I_Rd_Addr  out  1, BIT_ADDR  input buffer read; data returns next cycle
- I_Rd_Data  in  BIT_DATA  input buffer read data
- Data_W_Out, EN_W_Out, EN_ID_Out  out  BIT_DATA, 1, BIT_ROW_ID  to head PE weight port
- Data_I_Out  out  BIT_DATA  to head PE input port
- Addr_P_Out, Valid_P_Out  out  BIT_ADDR, 1  psum tag to head PE
- Cycle_Cnt  out  32  run length in cycles (see Configuration)

## Operation
- States: IDLE, LOAD_W, W_WAIT, STREAM, DRAIN, DONE.
- IDLE: Start=1 latches config registers. Next state is LOAD_W if Skip_W=0, otherwise STREAM if Num_Vec≠0, otherwise DONE.
- LOAD_W: NUM_ROW cycles. Cycle k asserts W_Rd_En with W_Rd_Addr = W_Base+k. Then W_WAIT.
- W_WAIT: NUM_ROW cycles, covering 1 read-latency cycle plus NUM_ROW−1 chain propagation cycles. Then STREAM, or DONE if Num_Vec=0.
- STREAM: Num_Vec cycles. Cycle j asserts I_Rd_En with I_Rd_Addr = I_Base+j. Then DRAIN.
- DRAIN: NUM_ROW+1 cycles, covering read latency plus NUM_ROW PE stages. Then DONE.
- DONE: Done=1 for one cycle, then IDLE.
- Weight-side alignment: EN_W_Out and EN_ID_Out are registered copies of W_Rd_En and k. They are high in the cycle W_Rd_Data is valid. Data_W_Out = W_Rd_Data (combinational pass-through).
- Input-side alignment: Valid_P_Out and Addr_P_Out (O_Base+j) are registered copies of I_Rd_En and the vector index. Data_I_Out = I_Rd_Data.
- Address arithmetic wraps modulo 2^BIT_ADDR. Num_Vec is unsigned, so 255 streams 255 vectors.
- Start while Busy is ignored. Config inputs are ignored outside the IDLE sampling cycle.
- RSTN low at any time, mid-run included, forces IDLE. Any in-flight weights/psums in the array are abandoned. Weights already latched in PEs remain; Skip_W=1 after reset is permitted but their contents are undefined.

## Timing
- Reset values: state IDLE; Busy, Done, W_Rd_En, I_Rd_En, EN_W_Out, Valid_P_Out = 0; W_Rd_Addr, I_Rd_Addr, EN_ID_Out, Addr_P_Out, Cycle_Cnt = 0.
- Cycle numbering: Start sampled in cycle 0; the first non-IDLE state is cycle 1.
- Full run: 2·NUM_ROW (weights) + Num_Vec + NUM_ROW+1 cycles, then DONE.
- W_Rd_En and I_Rd_En are never high in the same cycle.
- The first Valid_P_Out follows the last EN_W_Out by ≥NUM_ROW−1 cycles, so every row holds its new weight before the first vector reaches it.

## Configuration
- SYSTOLIC_CTRL_PERF_CNT_EN defined: Cycle_Cnt clears on accepted Start, increments every Busy cycle, and holds after DONE until the next Start. Its value equals the number of Busy cycles, DONE included.
- Not defined: Cycle_Cnt is constant 0 and no counter is synthesized.

## Test plan
- NUM_ROW=8, Num_Vec=4, Skip_W=0, W_Base=0x10, I_Base=0x20, O_Base=0x40, Start at cycle 0:
  - W_Rd_Addr 0x10..0x17 in cycles 1–8; EN_W_Out in cycles 2–9 with EN_ID 0..7.
  - I_Rd_Addr 0x20..0x23 in cycles 17–20; Valid_P_Out in cycles 18–21 with Addr_P_Out 0x40..0x43.
  - Done in cycle 30; Cycle_Cnt=30 with the macro, 0 without.
- Skip_W=1, Num_Vec=2, NUM_ROW=8 → no W_Rd_En; STREAM cycles 1–2; DRAIN cycles 3–11; Done in cycle 12.
- Skip_W=1, Num_Vec=0 → Done in cycle 1; no read enables ever asserted.
- I_Base=0xFE, Num_Vec=4 → I_Rd_Addr sequence 0xFE, 0xFF, 0x00, 0x01.
- Start pulsed again during STREAM → ignored; same Done cycle as a single Start; config unchanged.
- RSTN low in cycle 5 of LOAD_W → all outputs at reset values immediately; after RSTN high, a new Start runs the full sequence from cycle 1.

Source files
------------

// File: rtl/systolic_ctrl.sv
// Sequencer for the weight-stationary PE chain: weight load, settle, input stream, drain, done.
// Optional run-length counter enabled by defining SYSTOLIC_CTRL_PERF_CNT_EN.
module systolic_ctrl #(
  parameter int NUM_ROW    = 8,
  parameter int BIT_ROW_ID = 3,
  parameter int BIT_DATA   = 8,
  parameter int BIT_ADDR   = 8
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  Start,
  input  logic                  Skip_W,
  input  logic [BIT_ADDR-1:0]   Num_Vec,
  input  logic [BIT_ADDR-1:0]   W_Base,
  input  logic [BIT_ADDR-1:0]   I_Base,
  input  logic [BIT_ADDR-1:0]   O_Base,
  output logic                  Busy,
  output logic                  Done,
  output logic                  W_Rd_En,
  output logic [BIT_ADDR-1:0]   W_Rd_Addr,
  input  logic [BIT_DATA-1:0]   W_Rd_Data,
  output logic                  I_Rd_En,
  output logic [BIT_ADDR-1:0]   I_Rd_Addr,
  input  logic [BIT_DATA-1:0]   I_Rd_Data,
  output logic [BIT_DATA-1:0]   Data_W_Out,
  output logic                  EN_W_Out,
  output logic [BIT_ROW_ID-1:0] EN_ID_Out,
  output logic [BIT_DATA-1:0]   Data_I_Out,
  output logic [BIT_ADDR-1:0]   Addr_P_Out,
  output logic                  Valid_P_Out,
  output logic [31:0]           Cycle_Cnt
);

  // Counter must hold both vector indices and the NUM_ROW+1 drain length.
  localparam int CW = (BIT_ADDR > $clog2(NUM_ROW + 1)) ? BIT_ADDR : $clog2(NUM_ROW + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    W_WAIT,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                accept;
  logic [BIT_ADDR-1:0] num_vec_q, w_base_q, i_base_q, o_base_q;
  logic                last_row, last_vec, last_drain;

  assign last_row   = (cnt_q == CW'(NUM_ROW - 1));
  assign last_vec   = (cnt_q == (CW'(num_vec_q) - CW'(1)));
  assign last_drain = (cnt_q == CW'(NUM_ROW));

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          accept = 1'b1;
          cnt_d  = '0;
          if (!Skip_W)             state_d = LOAD_W;
          else if (Num_Vec != '0)  state_d = STREAM;
          else                     state_d = DONE;
        end
      end
      LOAD_W: begin
        if (last_row) begin
          cnt_d   = '0;
          state_d = W_WAIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      W_WAIT: begin
        if (last_row) begin
          cnt_d   = '0;
          state_d = (num_vec_q != '0) ? STREAM : DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STREAM: begin
        if (last_vec) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        if (last_drain) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      num_vec_q <= '0;
      w_base_q  <= '0;
      i_base_q  <= '0;
      o_base_q  <= '0;
    end else if (accept) begin
      num_vec_q <= Num_Vec;
      w_base_q  <= W_Base;
      i_base_q  <= I_Base;
      o_base_q  <= O_Base;
    end
  end

  assign Busy      = (state_q != IDLE);
  assign Done      = (state_q == DONE);
  assign W_Rd_En   = (state_q == LOAD_W);
  assign I_Rd_En   = (state_q == STREAM);
  assign W_Rd_Addr = W_Rd_En ? (w_base_q + BIT_ADDR'(cnt_q)) : '0;
  assign I_Rd_Addr = I_Rd_En ? (i_base_q + BIT_ADDR'(cnt_q)) : '0;

  // Tags are delayed one cycle so they line up with the buffer read data.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      EN_W_Out    <= 1'b0;
      EN_ID_Out   <= '0;
      Valid_P_Out <= 1'b0;
      Addr_P_Out  <= '0;
    end else begin
      EN_W_Out    <= W_Rd_En;
      EN_ID_Out   <= W_Rd_En ? BIT_ROW_ID'(cnt_q) : '0;
      Valid_P_Out <= I_Rd_En;
      Addr_P_Out  <= I_Rd_En ? (o_base_q + BIT_ADDR'(cnt_q)) : '0;
    end
  end

  assign Data_W_Out = W_Rd_Data;
  assign Data_I_Out = I_Rd_Data;

`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)       cycle_cnt_q <= '0;
    else if (accept) cycle_cnt_q <= '0;
    else if (Busy)   cycle_cnt_q <= cycle_cnt_q + 32'd1;
  end

  assign Cycle_Cnt = cycle_cnt_q;
`else
  assign Cycle_Cnt = '0;
`endif

endmodule
